// File: rtl/macc_dot_seq.sv
// macc_dot_seq: sequences (A,B) beats into an external MACC and returns the biased dot product
module macc_dot_seq #(
    parameter int WIDTH_A = 25,
    parameter int WIDTH_B = 18,
    parameter int WIDTH_P = 48,
    parameter int MACC_LAT = 3,
    parameter int MAX_LEN = 1024,
    localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               S_VALID,
    output logic               S_READY,
    input  logic [WIDTH_A-1:0] S_A,
    input  logic [WIDTH_B-1:0] S_B,
    input  logic               S_SUB,
    input  logic               S_LAST,
    input  logic [WIDTH_P-1:0] BIAS,
    output logic [WIDTH_A-1:0] M_A,
    output logic [WIDTH_B-1:0] M_B,
    output logic               M_ADDSUB,
    output logic               M_CARRYIN,
    output logic               M_CE,
    output logic               M_LOAD,
    output logic [WIDTH_P-1:0] M_LOAD_DATA,
    input  logic [WIDTH_P-1:0] M_P,
    output logic               R_VALID,
    input  logic               R_READY,
    output logic [WIDTH_P-1:0] R_DATA,
    output logic [CNT_W-1:0]   R_COUNT,
    output logic               R_OVF,
    output logic               BUSY
);
    localparam int DW = $clog2(MACC_LAT + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t           state, nstate;
    logic [CNT_W-1:0] count, cnt_nx;
    logic [DW-1:0]    dcnt;
    logic             acc, first, end_v, ovf_p;

    assign M_CARRYIN = 1'b0;

    // state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= nstate;
    end

    // next state: a vector ends on LAST or when it hits MAX_LEN beats
    always_comb begin
        nstate = state;
        case (state)
            IDLE:  if (acc) nstate = end_v ? DRAIN : ACCUM;
            ACCUM: if (acc && end_v) nstate = DRAIN;
            DRAIN: if (dcnt == '0) nstate = OUT;
            OUT:   if (R_READY) nstate = IDLE;
        endcase
    end

    // accept qualification and beat bookkeeping derived from state
    always_comb begin
        acc    = S_VALID & S_READY;
        first  = state == IDLE;
        cnt_nx = first ? CNT_W'(1) : count + 1'b1;
        end_v  = S_LAST | (cnt_nx == CNT_W'(MAX_LEN));
        BUSY   = state != IDLE;
    end

    // MACC issue registers; non-accept cycles issue a zero-product add bubble
    always_ff @(posedge CLK) begin
        if (RST) begin
            M_A         <= '0;
            M_B         <= '0;
            M_ADDSUB    <= 1'b1;
            M_CE        <= 1'b0;
            M_LOAD      <= 1'b0;
            M_LOAD_DATA <= '0;
        end else begin
            M_CE     <= 1'b1;
            M_A      <= acc ? S_A : '0;
            M_B      <= acc ? S_B : '0;
            M_ADDSUB <= acc ? ~S_SUB : 1'b1;
            M_LOAD   <= acc & first;
            if (acc && first) M_LOAD_DATA <= BIAS;
        end
    end

    // beat count, drain timer and result capture/hand-off
    always_ff @(posedge CLK) begin
        if (RST) begin
            S_READY <= 1'b0;
            count   <= '0;
            dcnt    <= '0;
            ovf_p   <= 1'b0;
            R_VALID <= 1'b0;
            R_DATA  <= '0;
            R_COUNT <= '0;
            R_OVF   <= 1'b0;
        end else begin
            S_READY <= nstate == IDLE || nstate == ACCUM;
            dcnt    <= state == DRAIN ? dcnt - 1'b1 : DW'(MACC_LAT);
            if (acc) begin
                count <= cnt_nx;
                ovf_p <= ~S_LAST;
            end
            if (state == DRAIN && dcnt == '0) begin
                R_VALID <= 1'b1;
                R_DATA  <= M_P;
                R_COUNT <= count;
                R_OVF   <= ovf_p;
            end else if (R_VALID && R_READY) begin
                R_VALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_macc_dot_seq.sv
// tb_macc_dot_seq: scoreboard bench with a behavioural MACC and a dot-product reference model
module tb_macc_dot_seq;
    localparam int WA = 25, WB = 18, WP = 48, L = 3, ML = 4;
    localparam int CW = $clog2(ML + 1);

    logic clk = 1'b0;
    logic RST, S_VALID, S_READY, S_SUB, S_LAST;
    logic [WA-1:0] S_A, M_A;
    logic [WB-1:0] S_B, M_B;
    logic [WP-1:0] BIAS, M_LOAD_DATA, R_DATA;
    logic [WP-1:0] mp = '0;
    logic M_ADDSUB, M_CARRYIN, M_CE, M_LOAD, R_VALID, R_READY, R_OVF, BUSY;
    logic [CW-1:0] R_COUNT;

    macc_dot_seq #(.WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_P(WP), .MACC_LAT(L), .MAX_LEN(ML)) dut (
        .CLK(clk), .RST(RST), .S_VALID(S_VALID), .S_READY(S_READY), .S_A(S_A), .S_B(S_B),
        .S_SUB(S_SUB), .S_LAST(S_LAST), .BIAS(BIAS), .M_A(M_A), .M_B(M_B), .M_ADDSUB(M_ADDSUB),
        .M_CARRYIN(M_CARRYIN), .M_CE(M_CE), .M_LOAD(M_LOAD), .M_LOAD_DATA(M_LOAD_DATA), .M_P(mp),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_COUNT(R_COUNT), .R_OVF(R_OVF),
        .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    typedef struct {logic [WP-1:0] d; int c; logic o; time t;} exp_t;
    typedef struct {logic ld; logic add; logic [WA-1:0] a; logic [WB-1:0] b; logic [WP-1:0] ldd;} mi_t;

    exp_t sq[$];
    mi_t pq[$];
    mi_t lat;
    logic lat_ce = 1'b0;
    logic [WP-1:0] pacc = '0;
    logic [WP-1:0] m_acc = '0;
    int m_cnt = 0;
    bit in_vec = 0, hold = 0, rnd = 0, pv = 0, hs = 0;
    int total = 0, bad = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    // behavioural MACC: inputs seen before an edge are registered, P settles L edges later
    always @(negedge clk) begin
        lat_ce = M_CE;
        lat = '{M_LOAD, M_ADDSUB, M_A, M_B, M_LOAD_DATA};
    end

    always @(posedge clk) begin : mac
        mi_t f;
        longint pr;
        logic [WP-1:0] base;
        if (lat_ce === 1'b1) begin
            pq.push_back(lat);
            if (pq.size() >= L) begin
                f = pq.pop_front();
                pr = longint'($signed(f.a)) * longint'($signed(f.b));
                base = f.ld ? f.ldd : pacc;
                pacc = f.add ? base + WP'(pr) : base - WP'(pr);
                mp <= pacc;
            end
        end
    end

    // reference: bias + sum(+/-a*b) mod 2^WP, a vector closes on LAST or after ML beats
    task automatic model_beat(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic sub,
                              input logic last, input logic [WP-1:0] bias, input time t);
        longint pr;
        pr = longint'($signed(a)) * longint'($signed(b));
        if (!in_vec) begin
            m_acc = bias;
            m_cnt = 0;
            in_vec = 1;
        end
        m_acc = sub ? m_acc - WP'(pr) : m_acc + WP'(pr);
        m_cnt++;
        if (last || m_cnt == ML) begin
            sq.push_back('{m_acc, m_cnt, !last, t});
            in_vec = 0;
        end
    endtask

    // result consumer
    initial begin
        R_READY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            R_READY = hold ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: compares every presented result against the scoreboard head
    always @(negedge clk) begin
        if (hs) chk("post_handshake", {R_VALID, S_READY}, 2'b01);
        if (R_VALID === 1'b1) begin
            chk("out_flags", {S_READY, BUSY}, 2'b01);
            if (sq.size() == 0) begin
                if (!pv) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result actual=%0h required=none", R_DATA);
                end
            end else begin
                chk("r_data", R_DATA, sq[0].d);
                chk("r_count", R_COUNT, sq[0].c);
                chk("r_ovf", R_OVF, sq[0].o);
                if (!pv) chk("latency", $time - sq[0].t, (L + 1) * 10 + 5);
                if (R_READY) void'(sq.pop_front());
            end
        end
        hs = R_VALID === 1'b1 && R_READY === 1'b1;
        pv = R_VALID === 1'b1;
    end

    task automatic send(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic sub,
                        input logic last, input logic [WP-1:0] bias, input int gap);
        int w;
        bit first;
        S_VALID = 1'b1; S_A = a; S_B = b; S_SUB = sub; S_LAST = last; BIAS = bias;
        w = 0;
        @(negedge clk);
        while (S_READY !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (S_READY !== 1'b1) begin
            chk("accept_timeout", {63'd0, S_READY}, 64'd1);
            S_VALID = 1'b0;
            return;
        end
        @(posedge clk);
        first = !in_vec;
        model_beat(a, b, sub, last, bias, $time);
        #1;
        S_VALID = 1'b0;
        S_A = WA'($urandom); S_B = WB'($urandom); S_SUB = 1'($urandom);
        S_LAST = 1'($urandom); BIAS = WP'({$urandom, $urandom});
        chk("issue", {M_A, M_B, M_ADDSUB, M_LOAD, M_CE, M_CARRYIN}, {a, b, ~sub, first, 1'b1, 1'b0});
        if (first) chk("load_data", M_LOAD_DATA, bias);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            if (g == 0) chk("bubble", {M_A, M_B, M_ADDSUB, M_LOAD}, 64'd2);
        end
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while ((sq.size() != 0 || R_VALID !== 1'b0) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) chk("drain_timeout", 64'(sq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        chk("rst_m", {M_A, M_B, M_CARRYIN, M_CE, M_LOAD, M_ADDSUB}, 64'd1);
        chk("rst_load_data", M_LOAD_DATA, 64'd0);
        chk("rst_r", {S_READY, R_VALID, R_OVF, BUSY, R_COUNT}, 64'd0);
        chk("rst_r_data", R_DATA, 64'd0);
    endtask

    initial begin
        RST = 1'b1; S_VALID = 1'b0; S_A = '0; S_B = '0; S_SUB = 1'b0; S_LAST = 1'b0; BIAS = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        RST = 1'b0;

        send(3, 4, 0, 1, 10, 0);
        wait_done();

        send(1, 2, 0, 0, 0, 0);
        send(3, 4, 0, 0, 0, 0);
        send(5, 6, 0, 0, 0, 0);
        send(7, 8, 0, 1, 0, 0);
        chk("s_ready_drain", {63'd0, S_READY}, 64'd0);
        wait_done();

        send(-5, 7, 0, 0, 100, 0);
        send(2, 3, 1, 1, 100, 0);
        wait_done();
        send(-5, 7, 0, 0, 100, 2);
        send(2, 3, 1, 1, 100, 2);
        wait_done();

        hold = 1;
        send(9, 9, 0, 1, 5, 0);
        fork
            begin
                repeat (14) @(posedge clk);
                hold = 0;
            end
        join_none
        send(2, 2, 0, 1, 0, 0);
        wait_done();

        for (int i = 0; i < 6; i++) send(1, 1, 0, i == 5, 0, 0);
        wait_done();

        send(5, 5, 0, 0, 3, 0);
        send(5, 5, 0, 0, 3, 0);
        RST = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        in_vec = 0;
        @(posedge clk);
        #1;
        RST = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(6, 7, 0, 1, 1, 0);
        wait_done();

        rnd = 1;
        for (int v = 0; v < 30; v++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++)
                send(WA'($urandom), WB'($urandom), 1'($urandom), i == len - 1,
                     WP'({$urandom, $urandom}), $urandom_range(0, 2));
        end
        wait_done();
        rnd = 0;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/macc_dot_seq.md
Name: macc_dot_seq

Overview:
- Initiator/sequencer that drives a DSP48E-based MACC_MACRO instance (7SERIES, external to this block) and collects its result.
- Accepts a stream of (A, B) operand pairs framed by a LAST flag. Issues one multiply-accumulate per beat to the MACC and seeds the accumulator with BIAS on the first beat of each vector.
- Waits out the MACC pipeline latency, then returns the dot-product result on a valid/ready output channel.
- Sits between the filter/dot-product datapath control and the MACC wrapper.

Parameters:
- WIDTH_A, 25, operand A width; must match the MACC WIDTH_A (1-25).
- WIDTH_B, 18, operand B width; must match the MACC WIDTH_B (1-18).
- WIDTH_P, 48, accumulator/result width; must match the MACC WIDTH_P (1-48).
- MACC_LAT, 3, MACC LATENCY setting (1-4).
- MAX_LEN, 1024, maximum beats per vector. CNT_W = clog2(MAX_LEN+1) is a localparam.

Ports:
- CLK  in  1  positive-edge clock.
- RST  in  1  synchronous active-high reset.
- S_VALID  in  1  input beat valid.
- S_READY  out  1  block can accept a beat.
- S_A  in  WIDTH_A  multiplier operand A.
- S_B  in  WIDTH_B  multiplier operand B.
- S_SUB  in  1  1 = subtract this product, 0 = add.
- S_LAST  in  1  final beat of the vector.
- BIAS  in  WIDTH_P  accumulator seed; sampled with the first beat.
- M_A  out  WIDTH_A  to MACC A.
- M_B  out  WIDTH_B  to MACC B.
- M_ADDSUB  out  1  to MACC ADDSUB (high = add).
- M_CARRYIN  out  1  to MACC CARRYIN; constant 0.
- M_CE  out  1  to MACC CE.
- M_LOAD  out  1  to MACC LOAD.
- M_LOAD_DATA  out  WIDTH_P  to MACC LOAD_DATA.
- M_P  in  WIDTH_P  from MACC P.
- R_VALID  out  1  result valid.
- R_READY  in  1  result consumer ready.
- R_DATA  out  WIDTH_P  dot-product result.
- R_COUNT  out  CNT_W  beats accumulated into R_DATA.
- R_OVF  out  1  vector was truncated at MAX_LEN.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset (RST=1 at an edge): state=IDLE. The following all go to 0: S_READY, M_A, M_B, M_CARRYIN, M_CE, M_LOAD, M_LOAD_DATA, R_VALID, R_DATA, R_COUNT, R_OVF, BUSY. M_ADDSUB resets to 1.
- Reset mid-vector aborts the vector and discards any MACC contents. Any in-flight result is dropped.
- M_CE is 1 in every cycle after reset is released; the MACC pipeline always advances.
- All M_* outputs are registered.
- Accept = S_VALID & S_READY.
- On an accept edge: M_A<=S_A, M_B<=S_B, M_ADDSUB<=~S_SUB. M_LOAD<=1 and M_LOAD_DATA<=BIAS on the first beat of a vector; otherwise M_LOAD<=0.
- On a non-accept edge: bubble issued, with M_A=0, M_B=0, M_ADDSUB=1, M_LOAD=0. This adds 0 and leaves the accumulator unchanged.
- MACC model: LOAD=1 gives P = LOAD_DATA ± A*B. LOAD=0 gives P = P ± A*B. A and B are signed two's complement.
- IDLE: S_READY=1. On accept, issue the first beat with LOAD, set count=1, then:
  - S_LAST=1 -> DRAIN;
  - otherwise -> ACCUM.
- ACCUM: S_READY=1. On accept, count++ and issue the beat. Go to DRAIN when S_LAST=1 or count reaches MAX_LEN.
  - If MAX_LEN is reached without S_LAST, the vector is truncated and R_OVF=1.
  - Beats after the truncation, up to and including S_LAST, start a new vector.
- DRAIN: S_READY=0, bubbles only. The drain counter is loaded with MACC_LAT on entry.
  - On the edge e0+MACC_LAT+1 (e0 = last-beat accept edge): R_DATA<=M_P, R_COUNT<=count, R_VALID<=1, state -> OUT.
- OUT: S_READY=0. R_VALID, R_DATA, R_COUNT and R_OVF are held stable until R_READY=1.
  - On the edge with R_VALID&R_READY: R_VALID<=0, state -> IDLE.
  - S_READY returns to 1 the following cycle; there is no cut-through.
- Latency: last beat accepted -> R_VALID = MACC_LAT+1 cycles (4 at default). Throughput is 1 beat/cycle within a vector.
- Gaps (S_VALID=0) inside a vector are legal and insert bubbles.
- Width: the result wraps modulo 2^WIDTH_P, matching the MACC. No saturation is applied.
- S_SUB, BIAS and S_LAST are ignored unless the beat is accepted. BIAS is ignored on non-first beats.

Test Plan:
- Reset, then a 1-beat vector: A=3, B=4, BIAS=10 -> R_DATA=22, R_COUNT=1, R_VALID 4 cycles after accept. M_LOAD=1 on the issue cycle.
- 4-beat vector (1,2),(3,4),(5,6),(7,8), BIAS=0, S_VALID held high -> R_DATA=100, R_COUNT=4. S_READY=0 from the cycle after the last accept until the cycle after R handshake.
- Signed/subtract: beats (-5,7,add),(2,3,sub), BIAS=100 -> R_DATA=100-35-6=59. Repeat with S_VALID gaps of 2 cycles between beats -> same result.
- Backpressure: hold R_READY=0 for 10 cycles -> R_DATA stable and S_VALID ignored. Then the next vector (2,2), BIAS=0 gives R_DATA=4, proving LOAD reseeds the accumulator.
- MAX_LEN=4 build: 6 beats of (1,1) with S_LAST on beat 6 -> result 1: R_DATA=4, R_COUNT=4, R_OVF=1. Result 2: R_DATA=2, R_COUNT=2, R_OVF=0.
- Assert RST during ACCUM after 2 beats -> all outputs at reset values next cycle, no R_VALID. Next vector (6,7), BIAS=1 -> R_DATA=43.
